// File: rtl/dma_mem_responder_pkg.sv
// Shared types for the DMA memory-side responder: FSM states, widths and the
// command word presented to the memory controller.
package dma_mem_pkg;
  localparam int AW = 21;
  localparam int DW = 16;

  typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/dma_mem_responder_if.sv
// DMA request port plus memory-controller command port. The master side is the
// DMA engine / memory controller pair; the slave side is the responder.
interface dma_mem_responder_if;
  import dma_mem_pkg::*;

  logic          slot_en;
  logic          dram_req;
  logic          dram_rnw;
  logic [AW-1:0] dram_addr;
  logic [DW-1:0] dram_wrdata;
  logic          dram_next;
  logic [DW-1:0] dram_rddata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    output slot_en, dram_req, dram_rnw, dram_addr, dram_wrdata,
           mem_ack, mem_rvalid, mem_rdata,
    input  dram_next, dram_rddata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  slot_en, dram_req, dram_rnw, dram_addr, dram_wrdata,
           mem_ack, mem_rvalid, mem_rdata,
    output dram_next, dram_rddata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dma_mem_responder_wr_post.sv
// Single-entry posted-write buffer: loaded when the DMA write is accepted,
// released when the memory controller acks the drain command.
module dma_wr_post
  import dma_mem_pkg::*;
#(
  parameter int A_W = AW,
  parameter int D_W = DW
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           load,
  input  logic [A_W-1:0] load_addr,
  input  logic [D_W-1:0] load_data,
  input  logic           drain_done,
  output logic           wb_valid,
  output logic [A_W-1:0] wb_addr,
  output logic [D_W-1:0] wb_data
);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else if (load) begin
      wb_valid <= 1'b1;
      wb_addr  <= load_addr;
      wb_data  <= load_data;
    end else if (drain_done) begin
      wb_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/dma_mem_responder.sv
// DMA DRAM-port responder: posts writes through a one-entry buffer and runs
// reads strictly behind any posted write, issuing req/ack memory commands.
module dma_mem_responder
  import dma_mem_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  dma_mem_responder_if.slave  bus,
  output logic                busy
);
  state_t        state;
  cmd_t          cmd;
  logic          mem_req;
  logic          dram_next;
  logic [DW-1:0] dram_rddata;
  logic [AW-1:0] rd_addr;

  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  logic wr_acc, rd_acc, cmd_free, drain_done;

  assign wr_acc     = bus.dram_req & ~bus.dram_rnw & ~wb_valid & ~dram_next;
  assign rd_acc     = bus.dram_req &  bus.dram_rnw & ~wb_valid & ~dram_next & (state == IDLE);
  assign cmd_free   = ~mem_req & (state == IDLE) & bus.slot_en;
  assign drain_done = mem_req & cmd.we & bus.mem_ack;

  dma_wr_post u_wb (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (wr_acc),
    .load_addr  (bus.dram_addr),
    .load_data  (bus.dram_wrdata),
    .drain_done (drain_done),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cmd         <= '0;
      mem_req     <= 1'b0;
      dram_next   <= 1'b0;
      dram_rddata <= '0;
      rd_addr     <= '0;
    end else begin
      dram_next <= wr_acc;

      // Command issue; accepting requests also launch the command directly so
      // a fresh write or read reaches the controller one cycle after sampling.
      if (mem_req) begin
        if (bus.mem_ack) mem_req <= 1'b0;
      end else if (cmd_free && wb_valid) begin
        mem_req <= 1'b1;
        cmd     <= '{we: 1'b1, addr: wb_addr, wdata: wb_data};
      end else if (cmd_free && wr_acc) begin
        mem_req <= 1'b1;
        cmd     <= '{we: 1'b1, addr: bus.dram_addr, wdata: bus.dram_wrdata};
      end else if (cmd_free && rd_acc) begin
        mem_req <= 1'b1;
        cmd     <= '{we: 1'b0, addr: bus.dram_addr, wdata: '0};
      end else if (state == RD_CMD && bus.slot_en) begin
        mem_req <= 1'b1;
        cmd     <= '{we: 1'b0, addr: rd_addr, wdata: '0};
      end

      case (state)
        IDLE: begin
          if (rd_acc) begin
            rd_addr <= bus.dram_addr;
            state   <= RD_CMD;
          end
        end
        RD_CMD: begin
          if (mem_req && bus.mem_ack) begin
            if (bus.mem_rvalid) begin
              dram_rddata <= bus.mem_rdata;
              dram_next   <= bus.dram_req;
              state       <= IDLE;
            end else begin
              state <= RD_DATA;
            end
          end
        end
        RD_DATA: begin
          // A dropped request means the DMA moved on; keep the data, skip the pulse.
          if (bus.mem_rvalid) begin
            dram_rddata <= bus.mem_rdata;
            dram_next   <= bus.dram_req;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dram_next   = dram_next;
  assign bus.dram_rddata = dram_rddata;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = cmd.we;
  assign bus.mem_addr    = cmd.addr;
  assign bus.mem_wdata   = cmd.wdata;
  assign busy            = (state != IDLE) | wb_valid;
endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench for dma_mem_responder: each step drives one cycle of DMA and
// memory-controller inputs and checks the registered outputs of that cycle.
module tb_dma_mem_responder;
  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  int   checks = 0;
  int   fails  = 0;
  logic [15:0] stored;

  dma_mem_responder_if bus ();

  dma_mem_responder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dma(input logic req, input logic rnw, input logic [20:0] a, input logic [15:0] d);
    bus.dram_req    = req;
    bus.dram_rnw    = rnw;
    bus.dram_addr   = a;
    bus.dram_wrdata = d;
  endtask

  task automatic mem(input logic ack, input logic rv, input logic [15:0] rd);
    bus.mem_ack    = ack;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rd;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_next"},   {31'd0, bus.dram_next}, 32'd0);
    chk({tag, "_memreq"}, {31'd0, bus.mem_req},   32'd0);
    chk({tag, "_busy"},   {31'd0, busy},          32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.slot_en = 1'b1;
    dma(1'b0, 1'b0, 21'h0, 16'h0);
    mem(1'b0, 1'b0, 16'h0);
    repeat (3) tick();
    chk_idle_outputs("rst");
    chk("rst_rddata", {16'd0, bus.dram_rddata}, 32'd0);
    chk("rst_we",     {31'd0, bus.mem_we},      32'd0);
    chk("rst_addr",   {11'd0, bus.mem_addr},    32'd0);
    reset_n = 1'b1;
    tick();

    // Single write, zero-wait ack.
    dma(1'b1, 1'b0, 21'h00123, 16'hBEEF);
    tick();
    chk("wr_next",  {31'd0, bus.dram_next}, 32'd1);
    chk("wr_req",   {31'd0, bus.mem_req},   32'd1);
    chk("wr_we",    {31'd0, bus.mem_we},    32'd1);
    chk("wr_addr",  {11'd0, bus.mem_addr},  32'h00123);
    chk("wr_wdata", {16'd0, bus.mem_wdata}, 32'hBEEF);
    chk("wr_busy",  {31'd0, busy},          32'd1);
    dma(1'b0, 1'b0, 21'h0, 16'h0);
    mem(1'b1, 1'b0, 16'h0);
    tick();
    mem(1'b0, 1'b0, 16'h0);
    chk_idle_outputs("wr_done");

    // Read after write to the same address, write ack delayed two cycles.
    dma(1'b1, 1'b0, 21'h00040, 16'hA5A5);
    tick();
    chk("raw_wnext", {31'd0, bus.dram_next}, 32'd1);
    dma(1'b1, 1'b1, 21'h00040, 16'h0);
    tick();
    chk("raw_hold_next", {31'd0, bus.dram_next}, 32'd0);
    chk("raw_hold_we",   {31'd0, bus.mem_we},    32'd1);
    tick();
    chk("raw_hold_req",  {31'd0, bus.mem_req},   32'd1);
    chk("raw_hold_we2",  {31'd0, bus.mem_we},    32'd1);
    stored = bus.mem_wdata;
    mem(1'b1, 1'b0, 16'h0);
    tick();
    mem(1'b0, 1'b0, 16'h0);
    chk("raw_gap_req", {31'd0, bus.mem_req}, 32'd0);
    tick();
    chk("raw_rd_req",  {31'd0, bus.mem_req}, 32'd1);
    chk("raw_rd_we",   {31'd0, bus.mem_we},  32'd0);
    chk("raw_rd_addr", {11'd0, bus.mem_addr}, 32'h00040);
    mem(1'b1, 1'b0, 16'h0);
    tick();
    mem(1'b0, 1'b1, stored);
    chk("raw_rdata_req", {31'd0, bus.mem_req}, 32'd0);
    tick();
    mem(1'b0, 1'b0, 16'h0);
    chk("raw_next",   {31'd0, bus.dram_next},   32'd1);
    chk("raw_rddata", {16'd0, bus.dram_rddata}, 32'hA5A5);
    dma(1'b0, 1'b0, 21'h0, 16'h0);
    tick();
    chk_idle_outputs("raw_done");

    // Slot starvation: five cycles without slot_en, then slot_en drops while held.
    bus.slot_en = 1'b0;
    dma(1'b1, 1'b1, 21'h00777, 16'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("starve_noreq", {31'd0, bus.mem_req}, 32'd0);
    end
    bus.slot_en = 1'b1;
    tick();
    chk("starve_req",  {31'd0, bus.mem_req},  32'd1);
    chk("starve_addr", {11'd0, bus.mem_addr}, 32'h00777);
    bus.slot_en = 1'b0;
    tick();
    chk("starve_hold_req",  {31'd0, bus.mem_req},  32'd1);
    chk("starve_hold_addr", {11'd0, bus.mem_addr}, 32'h00777);
    chk("starve_hold_next", {31'd0, bus.dram_next}, 32'd0);
    mem(1'b1, 1'b0, 16'h0);
    tick();
    mem(1'b0, 1'b1, 16'h5A5A);
    chk("starve_ackd_req", {31'd0, bus.mem_req}, 32'd0);
    tick();
    mem(1'b0, 1'b0, 16'h0);
    chk("starve_next",   {31'd0, bus.dram_next},   32'd1);
    chk("starve_rddata", {16'd0, bus.dram_rddata}, 32'h5A5A);
    dma(1'b0, 1'b0, 21'h0, 16'h0);
    bus.slot_en = 1'b1;
    tick();
    chk_idle_outputs("starve_done");

    // Zero-wait memory: ack and rvalid together.
    dma(1'b1, 1'b1, 21'h1FFFF, 16'h0);
    tick();
    chk("zw_req",  {31'd0, bus.mem_req},  32'd1);
    chk("zw_addr", {11'd0, bus.mem_addr}, 32'h1FFFF);
    chk("zw_busy", {31'd0, busy},         32'd1);
    mem(1'b1, 1'b1, 16'hC3C3);
    tick();
    mem(1'b0, 1'b0, 16'h0);
    chk("zw_next",   {31'd0, bus.dram_next},   32'd1);
    chk("zw_rddata", {16'd0, bus.dram_rddata}, 32'hC3C3);
    chk("zw_busy2",  {31'd0, busy},            32'd0);
    dma(1'b0, 1'b0, 21'h0, 16'h0);
    tick();
    chk("zw_next_once", {31'd0, bus.dram_next}, 32'd0);

    // Back-to-back writes: second accepted two cycles after the first.
    dma(1'b1, 1'b0, 21'h00010, 16'h1111);
    tick();
    chk("b2b_next1", {31'd0, bus.dram_next}, 32'd1);
    mem(1'b1, 1'b0, 16'h0);
    dma(1'b1, 1'b0, 21'h00011, 16'h2222);
    tick();
    mem(1'b0, 1'b0, 16'h0);
    chk("b2b_gap_next", {31'd0, bus.dram_next}, 32'd0);
    chk("b2b_gap_req",  {31'd0, bus.mem_req},   32'd0);
    tick();
    chk("b2b_next2", {31'd0, bus.dram_next}, 32'd1);
    chk("b2b_addr2", {11'd0, bus.mem_addr},  32'h00011);
    chk("b2b_data2", {16'd0, bus.mem_wdata}, 32'h2222);
    mem(1'b1, 1'b0, 16'h0);
    dma(1'b0, 1'b0, 21'h0, 16'h0);
    tick();
    mem(1'b0, 1'b0, 16'h0);
    chk_idle_outputs("b2b_done");

    // Aborted read: request drops in RD_DATA.
    dma(1'b1, 1'b1, 21'h00200, 16'h0);
    tick();
    mem(1'b1, 1'b0, 16'h0);
    tick();
    mem(1'b0, 1'b0, 16'h0);
    dma(1'b0, 1'b0, 21'h0, 16'h0);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    tick();
    mem(1'b0, 1'b1, 16'h1234);
    tick();
    mem(1'b0, 1'b0, 16'h0);
    chk("abort_next",   {31'd0, bus.dram_next},   32'd0);
    chk("abort_rddata", {16'd0, bus.dram_rddata}, 32'h1234);
    chk("abort_busy2",  {31'd0, busy},            32'd0);

    // Reset in RD_DATA, then a late ack/rvalid.
    dma(1'b1, 1'b1, 21'h00300, 16'h0);
    tick();
    mem(1'b1, 1'b0, 16'h0);
    tick();
    mem(1'b0, 1'b0, 16'h0);
    reset_n = 1'b0;
    dma(1'b0, 1'b0, 21'h0, 16'h0);
    tick();
    chk_idle_outputs("mrst");
    chk("mrst_rddata", {16'd0, bus.dram_rddata}, 32'd0);
    reset_n = 1'b1;
    tick();
    mem(1'b1, 1'b1, 16'h7777);
    tick();
    mem(1'b0, 1'b0, 16'h0);
    chk_idle_outputs("late");
    chk("late_rddata", {16'd0, bus.dram_rddata}, 32'd0);
    tick();
    chk("late_next2", {31'd0, bus.dram_next}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
